// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if
//   Bundles the three handshake channels around the FPU issue controller:
//     req_*      issue stage -> controller (valid/ready)
//     fpu_*      controller -> FPU wrapper request (valid/ready)
//     fpu_res_*  FPU wrapper -> controller result (valid only, no backpressure)
//     wb_*       controller -> commit writeback (valid/ready)
//   slave  : controller side (fpu_issue_ctrl)
//   master : environment side (issue stage, FPU wrapper, commit)
interface fpu_issue_ctrl_if #(
    parameter int TRANS_ID_BITS = 3,
    parameter int FLEN          = 64,
    parameter int OP_W          = 2,
    parameter int EXC_W         = 6
);
    logic                     req_valid;
    logic                     req_ready;
    logic [OP_W-1:0]          req_op;
    logic [1:0]               req_fmt;
    logic [2:0]               req_rm;
    logic [TRANS_ID_BITS-1:0] req_trans_id;

    logic                     fpu_valid;
    logic                     fpu_ready;
    logic [OP_W-1:0]          fpu_op;
    logic [1:0]               fpu_fmt;
    logic [2:0]               fpu_rm;
    logic [TRANS_ID_BITS-1:0] fpu_tid;

    logic                     fpu_res_valid;
    logic [TRANS_ID_BITS-1:0] fpu_res_tid;
    logic [FLEN-1:0]          fpu_res;
    logic [EXC_W-1:0]         fpu_res_exc;

    logic                     wb_valid;
    logic                     wb_ready;
    logic [TRANS_ID_BITS-1:0] wb_tid;
    logic [FLEN-1:0]          wb_result;
    logic [EXC_W-1:0]         wb_exc;

    modport slave (
        input  req_valid, req_op, req_fmt, req_rm, req_trans_id,
        output req_ready,
        output fpu_valid, fpu_op, fpu_fmt, fpu_rm, fpu_tid,
        input  fpu_ready,
        input  fpu_res_valid, fpu_res_tid, fpu_res, fpu_res_exc,
        output wb_valid, wb_tid, wb_result, wb_exc,
        input  wb_ready
    );

    modport master (
        output req_valid, req_op, req_fmt, req_rm, req_trans_id,
        input  req_ready,
        input  fpu_valid, fpu_op, fpu_fmt, fpu_rm, fpu_tid,
        output fpu_ready,
        output fpu_res_valid, fpu_res_tid, fpu_res, fpu_res_exc,
        input  wb_valid, wb_tid, wb_result, wb_exc,
        output wb_ready
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Initiator side of the FPU wrapper. Registers one op from the issue stage,
//   presents it to the FPU wrapper, tracks in-flight ops with a credit pool of
//   RES_DEPTH, and buffers unbackpressured results in a writeback FIFO drained
//   by commit. A credit covers an op from acceptance until its writeback pop,
//   so the FIFO can never overflow and no result is dropped. Flush empties the
//   issue register and FIFO, then drains (discards) results still in flight.
// Ports
//   clk_i, rst_i  clock, synchronous active-high reset
//   flush_i       discard all held, in-flight and buffered ops
//   busy_o        any op held, in flight or buffered
//   bus           fpu_issue_ctrl_if.slave: req_*, fpu_*, fpu_res_*, wb_*
//   perf_issued_o FPU handshake count      (FPU_ISSUE_PERF_EN only)
//   perf_stall_o  cycles of fpu_valid&!fpu_ready (FPU_ISSUE_PERF_EN only)
// Configuration
//   FPU_ISSUE_PERF_EN  adds the two 32-bit perf counters (cleared by reset only)
module fpu_issue_ctrl #(
    parameter int TRANS_ID_BITS = 3,
    parameter int FLEN          = 64,
    parameter int OP_W          = 2,
    parameter int EXC_W         = 6,
    parameter int RES_DEPTH     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
`ifdef FPU_ISSUE_PERF_EN
    output logic [31:0] perf_issued_o,
    output logic [31:0] perf_stall_o,
`endif
    output logic        busy_o,
    fpu_issue_ctrl_if.slave bus
);
    localparam int AW = $clog2(RES_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]               state, state_nxt;
    logic                     reg_full;
    logic [OP_W-1:0]          reg_op;
    logic [1:0]               reg_fmt;
    logic [2:0]               reg_rm;
    logic [TRANS_ID_BITS-1:0] reg_tid;
    logic [CW-1:0]            credits, credits_nxt;
    logic [CW-1:0]            inflight, inflight_nxt;
    logic [CW-1:0]            wr_ptr, rd_ptr, fifo_count;

    logic [TRANS_ID_BITS-1:0] mem_tid [RES_DEPTH];
    logic [FLEN-1:0]          mem_res [RES_DEPTH];
    logic [EXC_W-1:0]         mem_exc [RES_DEPTH];

    logic run, flush_run, req_fire, fpu_fire, res_ok, push, pop;

    assign run        = (state == ST_RUN);
    assign flush_run  = flush_i & run;
    assign fifo_count = wr_ptr - rd_ptr;

    // Back-to-back issue: a full register may refill in the cycle it hands off.
    assign bus.req_ready = run & (credits != '0) & (~reg_full | bus.fpu_ready);
    assign req_fire      = bus.req_valid & bus.req_ready & ~flush_i;
    assign fpu_fire      = reg_full & bus.fpu_ready;

    // A result with nothing in flight is stale (issued before a reset); ignore it.
    assign res_ok = bus.fpu_res_valid & (inflight != '0);
    assign push   = res_ok & run & ~flush_i;

    assign bus.wb_valid  = run & (fifo_count != '0);
    assign pop           = bus.wb_valid & bus.wb_ready & ~flush_i;
    assign bus.wb_tid    = bus.wb_valid ? mem_tid[rd_ptr[AW-1:0]] : '0;
    assign bus.wb_result = bus.wb_valid ? mem_res[rd_ptr[AW-1:0]] : '0;
    assign bus.wb_exc    = bus.wb_valid ? mem_exc[rd_ptr[AW-1:0]] : '0;

    assign bus.fpu_valid = reg_full;
    assign bus.fpu_op    = reg_op;
    assign bus.fpu_fmt   = reg_fmt;
    assign bus.fpu_rm    = reg_rm;
    assign bus.fpu_tid   = reg_tid;

    assign busy_o = reg_full | (inflight != '0) | (fifo_count != '0);

    // An op handed to the FPU in the flush cycle is already in flight and is
    // drained like the others, so it keeps its credit.
    assign inflight_nxt = inflight + CW'(fpu_fire) - CW'(res_ok);

    // NOTE: always_comb assigns every output a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        credits_nxt = credits;
        if (flush_run) begin
            credits_nxt = credits + fifo_count + CW'(reg_full & ~fpu_fire) + CW'(res_ok);
        end else if (!run) begin
            credits_nxt = credits + CW'(res_ok);
        end else begin
            credits_nxt = credits - CW'(req_fire) + CW'(pop);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (flush_i && inflight_nxt != '0) state_nxt = ST_DRAIN;
            ST_DRAIN: if (inflight_nxt == '0) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_RUN;
            reg_full <= 1'b0;
            reg_op   <= '0;
            reg_fmt  <= '0;
            reg_rm   <= '0;
            reg_tid  <= '0;
            credits  <= DEPTH_C;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            credits  <= credits_nxt;
            inflight <= inflight_nxt;

            if (flush_run) begin
                reg_full <= 1'b0;
            end else if (req_fire) begin
                reg_full <= 1'b1;
                reg_op   <= bus.req_op;
                reg_fmt  <= bus.req_fmt;
                reg_rm   <= bus.req_rm;
                reg_tid  <= bus.req_trans_id;
            end else if (fpu_fire) begin
                reg_full <= 1'b0;
            end

            if (flush_run) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + CW'(1);
                if (pop)  rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

    // NOTE: FIFO storage has no reset; the pointers define which entries are
    // valid and the head fields are gated to zero while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_tid[wr_ptr[AW-1:0]] <= bus.fpu_res_tid;
            mem_res[wr_ptr[AW-1:0]] <= bus.fpu_res;
            mem_exc[wr_ptr[AW-1:0]] <= bus.fpu_res_exc;
        end
    end

`ifdef FPU_ISSUE_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_issued_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (fpu_fire)                    perf_issued_o <= perf_issued_o + 32'd1;
            if (reg_full && !bus.fpu_ready)  perf_stall_o  <= perf_stall_o + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && fifo_count == DEPTH_C));
    a_credit_sum: assert property (@(posedge clk_i) disable iff (rst_i)
        (credits + CW'(reg_full) + inflight + fifo_count) == DEPTH_C);
`endif
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl
//   Self-checking bench for fpu_issue_ctrl. The bench plays issue stage, FPU
//   wrapper and commit. Every result it hands the DUT that must reach commit is
//   queued in a scoreboard; a monitor pops and compares on each writeback pop.
module tb_fpu_issue_ctrl;
    localparam int TIDW  = 3;
    localparam int FLEN  = 64;
    localparam int OP_W  = 2;
    localparam int EXC_W = 6;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [TIDW-1:0]  tid;
        logic [FLEN-1:0]  res;
        logic [EXC_W-1:0] exc;
    } wb_t;

    logic clk_i = 1'b0;
    logic rst_i;
    logic flush_i;
    logic busy_o;
`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] perf_issued_o;
    logic [31:0] perf_stall_o;
`endif

    fpu_issue_ctrl_if #(.TRANS_ID_BITS(TIDW), .FLEN(FLEN), .OP_W(OP_W), .EXC_W(EXC_W)) bus ();

    fpu_issue_ctrl #(
        .TRANS_ID_BITS(TIDW), .FLEN(FLEN), .OP_W(OP_W), .EXC_W(EXC_W), .RES_DEPTH(DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
`ifdef FPU_ISSUE_PERF_EN
        .perf_issued_o(perf_issued_o),
        .perf_stall_o (perf_stall_o),
`endif
        .busy_o       (busy_o),
        .bus          (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int tests_run = 0;
    int fails     = 0;
    int seq       = 0;
    logic [TIDW-1:0] next_tid = '0;
    wb_t sb[$];
    wb_t exp_wb;

    // Scoreboard monitor: commit pops happen at the next rising edge.
    always @(negedge clk_i) begin
        if (!rst_i && !flush_i && bus.wb_valid && bus.wb_ready) begin
            tests_run++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: popped tid=%0d but nothing expected", bus.wb_tid);
            end else begin
                exp_wb = sb.pop_front();
                if ({bus.wb_tid, bus.wb_result, bus.wb_exc} !== exp_wb) begin
                    fails++;
                    $display("FAIL wb_data: got tid=%0d res=%h exc=%h, want tid=%0d res=%h exc=%h",
                             bus.wb_tid, bus.wb_result, bus.wb_exc, exp_wb.tid, exp_wb.res, exp_wb.exc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic wb_t make_wb(input logic [TIDW-1:0] tid);
        wb_t w;
        w.tid = tid;
        w.res = {32'hC0DE_0000, 32'(seq)};
        w.exc = {5'(seq), 1'b1};
        seq++;
        return w;
    endfunction

    // One-cycle result beat from the FPU; queued only if commit must see it.
    task automatic send_result(input logic [TIDW-1:0] tid, input bit expect_push);
        wb_t w;
        w = make_wb(tid);
        bus.fpu_res_valid = 1'b1;
        bus.fpu_res_tid   = w.tid;
        bus.fpu_res       = w.res;
        bus.fpu_res_exc   = w.exc;
        if (expect_push) sb.push_back(w);
        tick();
        bus.fpu_res_valid = 1'b0;
    endtask

    // Offers up to 'want' ops; the FPU model answers each handshake on the next cycle.
    task automatic issue_loop(input int cycles, input int want, output int acc);
        bit              pend, acc_now, hs_now;
        logic [TIDW-1:0] ptid, hs_tid;
        wb_t             w;
        pend = 1'b0;
        ptid = '0;
        acc  = 0;
        for (int c = 0; c < cycles; c++) begin
            if (pend) begin
                w = make_wb(ptid);
                bus.fpu_res_valid = 1'b1;
                bus.fpu_res_tid   = w.tid;
                bus.fpu_res       = w.res;
                bus.fpu_res_exc   = w.exc;
                sb.push_back(w);
            end else begin
                bus.fpu_res_valid = 1'b0;
            end
            bus.req_valid    = (acc < want) && (c < cycles - 3);
            bus.req_trans_id = next_tid;
            bus.req_op       = next_tid[1:0];
            bus.req_fmt      = 2'd0;
            bus.req_rm       = 3'd1;
            #1;
            acc_now = bus.req_valid & bus.req_ready;
            hs_now  = bus.fpu_valid & bus.fpu_ready;
            hs_tid  = bus.fpu_tid;
            tick();
            if (acc_now) begin
                acc++;
                next_tid++;
            end
            pend = hs_now;
            ptid = hs_tid;
        end
        bus.req_valid     = 1'b0;
        bus.fpu_res_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.wb_ready = 1'b1;
        while (sb.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results still expected, want 0", sb.size());
        end
        tick();
        tests_run++;
        if (busy_o !== 1'b0 || bus.wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_idle: busy=%b wb_valid=%b, want 0 0", busy_o, bus.wb_valid);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        flush_i = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_fmt = '0; bus.req_rm = '0; bus.req_trans_id = '0;
        bus.fpu_ready = 1'b0; bus.fpu_res_valid = 1'b0; bus.fpu_res_tid = '0;
        bus.fpu_res = '0; bus.fpu_res_exc = '0; bus.wb_ready = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
        end
        tests_run++;
        if ({bus.fpu_valid, bus.wb_valid, busy_o} !== 3'b000) begin
            fails++; $display("FAIL reset_valids: fpu_valid/wb_valid/busy=%b want 000",
                              {bus.fpu_valid, bus.wb_valid, busy_o});
        end
        tests_run++;
        if (bus.fpu_tid !== '0 || bus.wb_tid !== '0 || bus.wb_result !== '0) begin
            fails++; $display("FAIL reset_fields: fpu_tid=%0d wb_tid=%0d wb_result=%h want 0",
                              bus.fpu_tid, bus.wb_tid, bus.wb_result);
        end
`ifdef FPU_ISSUE_PERF_EN
        tests_run++;
        if (perf_issued_o !== 32'd0 || perf_stall_o !== 32'd0) begin
            fails++; $display("FAIL reset_perf: issued=%0d stall=%0d want 0 0", perf_issued_o, perf_stall_o);
        end
`endif
    endtask

    task automatic test_single_op();
        tick();
        bus.fpu_ready = 1'b1;
        bus.wb_ready  = 1'b1;
        bus.req_valid = 1'b1; bus.req_trans_id = 3'd3; bus.req_op = 2'd2; bus.req_fmt = 2'd1; bus.req_rm = 3'd5;
        tick();
        bus.req_valid = 1'b0;
        tests_run++;
        if ({bus.fpu_valid, bus.fpu_tid, bus.fpu_op, bus.fpu_fmt, bus.fpu_rm} !== {1'b1, 3'd3, 2'd2, 2'd1, 3'd5}) begin
            fails++; $display("FAIL single_fpu_req: valid=%b tid=%0d op=%0d fmt=%0d rm=%0d want 1 3 2 1 5",
                              bus.fpu_valid, bus.fpu_tid, bus.fpu_op, bus.fpu_fmt, bus.fpu_rm);
        end
        tick();
        tests_run++;
        if (bus.fpu_valid !== 1'b0 || busy_o !== 1'b1) begin
            fails++; $display("FAIL single_inflight: fpu_valid=%b busy=%b want 0 1", bus.fpu_valid, busy_o);
        end
        tick();
        tick();
        send_result(3'd3, 1'b1);
        tests_run++;
        if (bus.wb_valid !== 1'b1 || bus.wb_tid !== 3'd3) begin
            fails++; $display("FAIL single_wb: wb_valid=%b wb_tid=%0d want 1 3", bus.wb_valid, bus.wb_tid);
        end
        tick();
        tests_run++;
        if (bus.wb_valid !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL single_done: wb_valid=%b busy=%b want 0 0", bus.wb_valid, busy_o);
        end
    endtask

    task automatic test_stall();
        bus.fpu_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_trans_id = 3'd5; bus.req_op = 2'd1; bus.req_fmt = 2'd2; bus.req_rm = 3'd3;
        tick();
        bus.req_valid = 1'b0; bus.req_trans_id = 3'd7; bus.req_op = 2'd3; bus.req_fmt = 2'd0; bus.req_rm = 3'd0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({bus.fpu_valid, bus.fpu_tid, bus.fpu_op, bus.fpu_fmt, bus.fpu_rm} !== {1'b1, 3'd5, 2'd1, 2'd2, 3'd3}) begin
                fails++; $display("FAIL stall_hold[%0d]: valid=%b tid=%0d op=%0d fmt=%0d rm=%0d want 1 5 1 2 3",
                                  i, bus.fpu_valid, bus.fpu_tid, bus.fpu_op, bus.fpu_fmt, bus.fpu_rm);
            end
            tests_run++;
            if (bus.req_ready !== 1'b0) begin
                fails++; $display("FAIL stall_req_ready[%0d]: got %b want 0", i, bus.req_ready);
            end
            tick();
        end
`ifdef FPU_ISSUE_PERF_EN
        tests_run++;
        if (perf_stall_o !== 32'd5) begin
            fails++; $display("FAIL stall_perf: got %0d want 5", perf_stall_o);
        end
`endif
        bus.fpu_ready = 1'b1;
        tick();
        tests_run++;
        if (bus.fpu_valid !== 1'b0) begin
            fails++; $display("FAIL stall_release: fpu_valid=%b want 0", bus.fpu_valid);
        end
`ifdef FPU_ISSUE_PERF_EN
        tests_run++;
        if (perf_issued_o !== 32'd2) begin
            fails++; $display("FAIL stall_perf_issued: got %0d want 2", perf_issued_o);
        end
`endif
        tick();
        send_result(3'd5, 1'b1);
        tick();
        tests_run++;
        if (busy_o !== 1'b0) begin
            fails++; $display("FAIL stall_done: busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_credits();
        int acc;
        bus.wb_ready  = 1'b0;
        bus.fpu_ready = 1'b1;
        issue_loop(14, 6, acc);
        tests_run++;
        if (acc !== 4) begin
            fails++; $display("FAIL credits_accepts: got %0d want 4", acc);
        end
        tests_run++;
        if (bus.req_ready !== 1'b0 || bus.wb_valid !== 1'b1) begin
            fails++; $display("FAIL credits_exhausted: req_ready=%b wb_valid=%b want 0 1", bus.req_ready, bus.wb_valid);
        end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL credits_one_back: req_ready=%b want 1", bus.req_ready);
        end
        issue_loop(10, 6, acc);
        tests_run++;
        if (acc !== 1) begin
            fails++; $display("FAIL credits_single_refill: got %0d accepts want 1", acc);
        end
        drain();
    endtask

    task automatic test_push_pop_full();
        int acc;
        int pops;
        bus.wb_ready = 1'b0;
        issue_loop(12, 3, acc);
        tests_run++;
        if (acc !== 3) begin
            fails++; $display("FAIL pp_fill: got %0d accepts want 3", acc);
        end
        bus.req_valid = 1'b1; bus.req_trans_id = next_tid; bus.req_op = 2'd0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tests_run++;
        if (bus.req_ready !== 1'b0) begin
            fails++; $display("FAIL pp_no_credit: req_ready=%b want 0", bus.req_ready);
        end
        bus.wb_ready = 1'b1;
        send_result(next_tid, 1'b1);
        next_tid++;
        bus.wb_ready = 1'b0;
        tests_run++;
        if (bus.wb_valid !== 1'b1 || bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL pp_after: wb_valid=%b req_ready=%b want 1 1", bus.wb_valid, bus.req_ready);
        end
        pops = 0;
        bus.wb_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (bus.wb_valid) pops++;
            tick();
        end
        tests_run++;
        if (pops !== 3) begin
            fails++; $display("FAIL pp_count: got %0d entries want 3", pops);
        end
        tests_run++;
        if (sb.size() != 0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL pp_empty: %0d still expected busy=%b want 0 0", sb.size(), busy_o);
        end
    endtask

    task automatic test_flush_drain();
        bus.fpu_ready = 1'b1;
        bus.wb_ready  = 1'b1;
        bus.req_valid = 1'b1; bus.req_trans_id = 3'd1;
        tick();
        bus.req_trans_id = 3'd2;
        #1;
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL flush_back_to_back: req_ready=%b want 1", bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tests_run++;
        if ({bus.req_ready, bus.wb_valid, busy_o} !== 3'b001) begin
            fails++; $display("FAIL flush_drain: req_ready/wb_valid/busy=%b want 001",
                              {bus.req_ready, bus.wb_valid, busy_o});
        end
        send_result(3'd1, 1'b0);
        tests_run++;
        if ({bus.req_ready, bus.wb_valid} !== 2'b00) begin
            fails++; $display("FAIL flush_first_result: req_ready/wb_valid=%b want 00", {bus.req_ready, bus.wb_valid});
        end
        send_result(3'd2, 1'b0);
        tests_run++;
        if ({bus.req_ready, bus.wb_valid, busy_o} !== 3'b100) begin
            fails++; $display("FAIL flush_back_to_run: req_ready/wb_valid/busy=%b want 100",
                              {bus.req_ready, bus.wb_valid, busy_o});
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        bus.wb_ready  = 1'b0;
        bus.fpu_ready = 1'b1;
        issue_loop(12, 3, acc);
        tests_run++;
        if (acc !== 3 || busy_o !== 1'b1) begin
            fails++; $display("FAIL rstmid_fill: accepts=%0d busy=%b want 3 1", acc, busy_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        sb.delete();
        tests_run++;
        if ({bus.wb_valid, busy_o, bus.req_ready} !== 3'b001) begin
            fails++; $display("FAIL rstmid_state: wb_valid/busy/req_ready=%b want 001",
                              {bus.wb_valid, busy_o, bus.req_ready});
        end
`ifdef FPU_ISSUE_PERF_EN
        tests_run++;
        if (perf_issued_o !== 32'd0) begin
            fails++; $display("FAIL rstmid_perf_clear: got %0d want 0", perf_issued_o);
        end
`endif
        send_result(3'd4, 1'b0);
        tests_run++;
        if (bus.wb_valid !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL rstmid_stale_result: wb_valid=%b busy=%b want 0 0", bus.wb_valid, busy_o);
        end
        issue_loop(14, 6, acc);
        tests_run++;
        if (acc !== DEPTH) begin
            fails++; $display("FAIL rstmid_credits: got %0d accepts want %0d", acc, DEPTH);
        end
`ifdef FPU_ISSUE_PERF_EN
        tests_run++;
        if (perf_issued_o !== 32'd4) begin
            fails++; $display("FAIL rstmid_perf_issued: got %0d want 4", perf_issued_o);
        end
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_stall();
        test_credits();
        test_push_pop_full();
        test_flush_drain();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
